// File: rtl/mem_resp_pkg.sv
// Shared types and default build constants for the MEM-stage data-memory responder.
package mem_resp_pkg;

  localparam int DEF_LATENCY     = 3;
  localparam int DEF_DEPTH_WORDS = 256;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic {
    OP_LOAD,
    OP_STORE
  } mem_op_t;

endpackage

// File: rtl/data_memory_array.sv
// Single-port synchronous word RAM with write enable and registered read; contents are never reset.
module data_memory_array #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk_i,
  input  logic                           wr_en,
  input  logic                           rd_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[addr] <= wdata;
    if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle load/store responder: stalls the pipeline for LATENCY cycles per access,
// commits on the edge into DONE and presents load data during the single DONE cycle.
module data_memory_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int AW   = $clog2(DEPTH_WORDS);
  localparam int CW   = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam bit FAST = (LATENCY == 1);
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          zero_q;

  mem_op_t       op_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          ill_q;

  logic          req, accept, commit, ill_in;
  mem_op_t       op_in, c_op;
  logic [AW-1:0] idx_in, c_idx;
  logic [31:0]   c_wdata;
  logic          c_ill;
  logic          ram_we, ram_re;
  logic [31:0]   ram_rdata;

  assign req    = MemRead_i | MemWrite_i;
  assign accept = (state == IDLE) && req && !rst_i;
  assign op_in  = MemWrite_i ? OP_STORE : OP_LOAD;
  assign idx_in = addr_i[AW+1:2];
  assign ill_in = (addr_i[1:0] != 2'b00) || ((addr_i >> (AW + 2)) != 32'd0)
                  || (MemRead_i && MemWrite_i);

  // With a one-cycle latency the access commits straight from the inputs in IDLE.
  assign commit  = FAST ? accept : ((state == BUSY) && (cnt == '0) && !rst_i);
  assign c_op    = FAST ? op_in  : op_q;
  assign c_idx   = FAST ? idx_in : idx_q;
  assign c_wdata = FAST ? data_i : wdata_q;
  assign c_ill   = FAST ? ill_in : ill_q;

  assign ram_we = commit && (c_op == OP_STORE) && !c_ill;
  assign ram_re = commit && (c_op == OP_LOAD) && !c_ill;

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    case (state)
      IDLE: begin
        stall_o = req && !rst_i;
        if (req) state_nxt = FAST ? DONE : BUSY;
      end
      BUSY: begin
        stall_o = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      err_o  <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) cnt <= CNT_INIT;
      else if ((state == BUSY) && (cnt != '0)) cnt <= cnt - 1'b1;
      if (commit && c_ill) err_o <= 1'b1;
      if (commit && (c_op == OP_LOAD)) zero_q <= c_ill;
    end
  end

  // Request capture stage: held for the duration of the access.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q    <= op_in;
      idx_q   <= idx_in;
      wdata_q <= data_i;
      ill_q   <= ill_in;
    end
  end

  data_memory_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i (clk_i),
    .wr_en (ram_we),
    .rd_en (ram_re),
    .addr  (c_idx),
    .wdata (c_wdata),
    .rdata (ram_rdata)
  );

  // RAM read register only moves on legal loads; zero_q covers reset and illegal loads.
  assign data_o = zero_q ? 32'd0 : ram_rdata;

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Multi-cycle data-memory responder for the MEM stage of the 5-stage pipeline. Accepts load and store requests from the EX/MEM pipeline register outputs and services each one over a fixed, parameterised latency. It stalls the pipeline for that latency, then presents load data to the MEM/WB register in a single unstalled cycle. It is the responder end of the MemRead/MemWrite request interface driven by the pipeline.

## Interface

**Parameters**
- DEPTH_WORDS, default 256: number of 32-bit words. Must be a power of two, at least 4.
- LATENCY, default 3: stall cycles per access. Must be at least 1.

**Ports**
- clk_i, input, 1: clock. Everything is posedge.
- rst_i, input, 1: reset. Synchronous and active-high.
- MemRead_i, input, 1: load request, level-sensitive. Held by the pipeline while stall_o is high.
- MemWrite_i, input, 1: store request, level-sensitive. Held by the pipeline while stall_o is high.
- addr_i, input, 32: byte address from ALUResult.
- data_i, input, 32: store data from RS2data.
- data_o, output, 32: load data. Registered.
- stall_o, output, 1: freeze request. Asserted while an access is in progress.
- err_o, output, 1: sticky access-error flag.

## Operation

- Derived constant: AW = clog2(DEPTH_WORDS).
- Word index is addr_i[AW+1:2].
- The access is **illegal** if addr_i[1:0] != 0, or addr_i[31:AW+2] != 0, or MemRead_i and MemWrite_i are both high.
- States:
  - IDLE: no access in progress.
  - BUSY: access in progress, cycle counter `cnt` running.
  - DONE: single completion cycle.
- IDLE:
  - req = MemRead_i | MemWrite_i.
  - If req: latch op, word index, data_i and the illegal flag.
  - If LATENCY == 1, go to DONE; otherwise go to BUSY with cnt = LATENCY-2.
- BUSY: decrement cnt. When cnt == 0, go to DONE.
- Commit happens on the edge into DONE:
  - Legal store: write the latched data to the latched index.
  - Legal load: data_o <= mem[index].
  - Illegal load: data_o <= 0.
  - Illegal access of any kind: no memory write, and err_o <= 1.
- DONE: stall_o = 0 and the pipeline advances. Always return to IDLE next cycle. The request still present on the inputs during DONE is never re-accepted.
- data_o holds its value until the next load commit. Stores do not change data_o.
- err_o stays high until rst_i.
- Read and write both high counts as illegal. It is treated as a store for timing, but memory is not written.
- Reset mid-access, in any state:
  - Return to IDLE and clear cnt.
  - Drop any pending store.
  - data_o = 0 and err_o = 0.
  - Memory contents are not cleared.

## Timing

- Reset values: data_o = 0, stall_o = 0, err_o = 0, state = IDLE.
- stall_o = (state == IDLE & req & ~rst_i) | (state == BUSY). It is combinational, so the stall is seen in the same cycle the request appears.
- An access presented in cycle T:
  - stall_o is high in cycles T .. T+LATENCY-1.
  - DONE occurs in cycle T+LATENCY.
  - data_o is valid from T+LATENCY, in time to be captured by MEM/WB at the end of that cycle.
- Back-to-back: a new request arriving in cycle T+LATENCY+1 is accepted immediately. Sustained throughput is one access per LATENCY+1 cycles.
- A cycle with no request in IDLE costs nothing: stall_o stays 0.
- A store followed immediately by a load to the same word returns the new data.

## Structure

Shared package `mem_resp_pkg`:
- State enum {IDLE, BUSY, DONE}.
- Default LATENCY and DEPTH_WORDS constants.
- An `mem_op_t` enum {OP_LOAD, OP_STORE}.

One sub-module, `data_memory_array`:
- Single-port synchronous RAM, DEPTH_WORDS × 32.
- Write enable, registered read.
- No reset of contents.
- Owned by the FSM top. The read is launched in the final BUSY cycle, or in IDLE when LATENCY == 1.

## Test plan

- **Reset.** Assert rst_i for 2 cycles → data_o = 0, stall_o = 0, err_o = 0.
- **Store then load.**
  - Store 0xDEADBEEF to 0x10 with LATENCY = 3 → stall_o high for exactly 3 cycles, then low.
  - Load from 0x10 → data_o = 0xDEADBEEF in cycle T+3, where T is the cycle the load is presented.
  - A request held on the inputs through DONE is not re-accepted.
- **Back-to-back.**
  - Stores to 0x0, 0x4 and 0x8 in consecutive accept windows, followed by loads of all three → each returns its own value.
  - Total cycles = 6 × (LATENCY + 1).
- **Illegal accesses.**
  - Store to 0x13 (misaligned) → memory unchanged, err_o = 1 from the DONE cycle, stall still lasts LATENCY cycles.
  - Load from 0x400 with DEPTH_WORDS = 256 → data_o = 0, err_o stays 1.
  - MemRead_i and MemWrite_i both high → err_o = 1, no write.
- **Reset mid-access.** Assert rst_i in the second BUSY cycle of a store of 0x12345678 to 0x20 → state returns to IDLE, stall_o = 0. A later load from 0x20 returns the prior contents, not 0x12345678.
- **LATENCY = 1 build.**
  - Load → stall_o high for 1 cycle, data_o valid in the next cycle.
  - An idle cycle with no request keeps stall_o = 0.
